sync_gen: RTL and testbench

Transmit-side frame/sync generator for the modem burst path. It emits one symbol per `iena` strobe. Each frame starts with a fixed `pSYNC_LEN`-symbol preamble, marked by `osop` on its first symbol. The preamble is followed by payload symbols pulled from an upstream valid/ready source, for a total of `frame_time` symbols per frame. At each frame end it reports the number of payload underruns, so the receive-side peak statistics can be cross-checked against the sent frame count.

---
 rtl/sync_pkg.sv | 21 ++
 rtl/sync_seq_rom.sv | 31 +++
 rtl/sync_gen.sv | 177 +++++++++++++++++
 tb/tb_sync_gen.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Constants and types shared by the burst-path sync generator and the receive correlator.
package sync_pkg;

   // Preamble bit pattern. Symbol k of an N-symbol preamble uses bit 63-k, so only the top N bits are used.
   localparam logic [63:0] SYNC_SEQ = 64'hB45A_C3E1_9F2D_7086;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      DATA
   } state_e;

   function automatic logic [63:0] sync_p(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] sync_n(input int w);
      return ~sync_p(w) + 64'd1;
   endfunction

endpackage

// File: rtl/sync_seq_rom.sv
// Preamble lookup: maps a symbol index to +/-full-scale, registered so it lines up with the payload register.
module sync_seq_rom #(
   parameter int pDAT_W = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     en_i,
   input  logic [5:0]               idx_i,
   output logic signed [pDAT_W-1:0] sym_o
);
   import sync_pkg::*;

   localparam logic [pDAT_W-1:0] SymP = pDAT_W'(sync_p(pDAT_W));
   localparam logic [pDAT_W-1:0] SymN = pDAT_W'(sync_n(pDAT_W));

   logic [5:0]               bitIdx;
   logic signed [pDAT_W-1:0] sym_q;

   assign bitIdx = 6'd63 - idx_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sym_q <= '0;
      end else if (en_i) begin
         sym_q <= SYNC_SEQ[bitIdx] ? SymP : SymN;
      end
   end

   assign sym_o = sym_q;

endmodule

// File: rtl/sync_gen.sv
// Transmit frame generator: preamble, then payload from a valid/ready source, with per-frame underrun stats.
module sync_gen #(
   parameter int pDAT_W    = 8,
   parameter int pTM_W     = 24,
   parameter int pSYNC_LEN = 32,
   parameter int pST_W     = 8
) (
   input  logic                     iclk,
   input  logic                     ireset,
   input  logic                     iena,
   input  logic                     irun,
   input  logic [pTM_W-1:0]         frame_time,
   input  logic signed [pDAT_W-1:0] idat,
   input  logic                     ival,
   output logic                     ordy,
   output logic signed [pDAT_W-1:0] odat,
   output logic                     oval,
   output logic                     osop,
   output logic                     oeof,
   output logic [pST_W-1:0]         ounder,
   output logic                     ostat_val
);
   import sync_pkg::*;

   localparam logic [pTM_W-1:0] MinFt    = pTM_W'(pSYNC_LEN + 1);
   localparam logic [pTM_W-1:0] LastSync = pTM_W'(pSYNC_LEN - 1);

   state_e                   state_q, state_d;
   logic [pTM_W-1:0]         cntSym_q, cntSym_d;
   logic [pTM_W-1:0]         ftLat_q, ftLat_d;
   logic [pST_W-1:0]         cntUnder_q, cntUnder_d;
   logic [pST_W-1:0]         ounder_q, ounder_d;
   logic                     statPend_q, statPend_d;
   logic                     stat_q, stat_d;
   logic signed [pDAT_W-1:0] dat_q, dat_d;
   logic                     selSync_q, selSync_d;
   logic                     oval_q, oval_d;
   logic                     osop_q, osop_d;
   logic                     oeof_q, oeof_d;

   logic [pTM_W-1:0]         ftClamp;
   logic                     lastSym;
   logic                     romEn;
   logic [5:0]               romIdx;
   logic signed [pDAT_W-1:0] romSym;

   assign ftClamp = (frame_time < MinFt) ? MinFt : frame_time;
   assign lastSym = (cntSym_q == ftLat_q - 1'b1);

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         state_q    <= IDLE;
         cntSym_q   <= '0;
         ftLat_q    <= '0;
         cntUnder_q <= '0;
         ounder_q   <= '0;
         statPend_q <= 1'b0;
         stat_q     <= 1'b0;
         dat_q      <= '0;
         selSync_q  <= 1'b0;
         oval_q     <= 1'b0;
         osop_q     <= 1'b0;
         oeof_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cntSym_q   <= cntSym_d;
         ftLat_q    <= ftLat_d;
         cntUnder_q <= cntUnder_d;
         ounder_q   <= ounder_d;
         statPend_q <= statPend_d;
         stat_q     <= stat_d;
         dat_q      <= dat_d;
         selSync_q  <= selSync_d;
         oval_q     <= oval_d;
         osop_q     <= osop_d;
         oeof_q     <= oeof_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cntSym_d   = cntSym_q;
      ftLat_d    = ftLat_q;
      cntUnder_d = cntUnder_q;
      ounder_d   = ounder_q;
      statPend_d = 1'b0;
      stat_d     = 1'b0;
      dat_d      = dat_q;
      selSync_d  = selSync_q;
      oval_d     = 1'b0;
      osop_d     = 1'b0;
      oeof_d     = 1'b0;
      ordy       = 1'b0;
      romEn      = 1'b0;
      romIdx     = cntSym_q[5:0];

      // Stats publish one cycle after the eof beat, independent of the strobe.
      if (statPend_q) begin
         ounder_d   = cntUnder_q;
         cntUnder_d = '0;
         stat_d     = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (irun && iena) begin
               ftLat_d   = ftClamp;
               cntSym_d  = {{(pTM_W-1){1'b0}}, 1'b1};
               romEn     = 1'b1;
               romIdx    = 6'd0;
               selSync_d = 1'b1;
               oval_d    = 1'b1;
               osop_d    = 1'b1;
               state_d   = SYNC;
            end
         end
         SYNC: begin
            if (iena) begin
               romEn     = 1'b1;
               selSync_d = 1'b1;
               oval_d    = 1'b1;
               osop_d    = (cntSym_q == '0);
               cntSym_d  = cntSym_q + 1'b1;
               if (cntSym_q == LastSync) begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (iena) begin
               ordy      = 1'b1;
               oval_d    = 1'b1;
               selSync_d = 1'b0;
               if (ival) begin
                  dat_d = idat;
               end else begin
                  dat_d      = '0;
                  cntUnder_d = (&cntUnder_q) ? cntUnder_q : cntUnder_q + 1'b1;
               end
               if (lastSym) begin
                  // Re-latching here lets the next frame start on the very next strobe.
                  oeof_d     = 1'b1;
                  statPend_d = 1'b1;
                  cntSym_d   = '0;
                  if (irun) begin
                     ftLat_d = ftClamp;
                     state_d = SYNC;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  cntSym_d = cntSym_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   sync_seq_rom #(
      .pDAT_W(pDAT_W)
   ) uRom (
      .clk_i (iclk),
      .rst_ni(ireset),
      .en_i  (romEn),
      .idx_i (romIdx),
      .sym_o (romSym)
   );

   assign odat      = selSync_q ? romSym : dat_q;
   assign oval      = oval_q;
   assign osop      = osop_q;
   assign oeof      = oeof_q;
   assign ounder    = ounder_q;
   assign ostat_val = stat_q;

endmodule

// File: tb/tb_sync_gen.sv
// Randomized bench for sync_gen against a frame-level reference model (position in frame, frame length, underruns).
module tb_sync_gen;

   localparam int DatW    = 8;
   localparam int TmW     = 24;
   localparam int SyncLen = 8;
   localparam int StW     = 4;

   logic                   iclk = 1'b0;
   logic                   ireset = 1'b0;
   logic                   iena = 1'b0;
   logic                   irun = 1'b0;
   logic                   ival = 1'b0;
   logic [TmW-1:0]         frame_time = 24'd20;
   logic signed [DatW-1:0] idat = '0;
   logic                   ordy;
   logic signed [DatW-1:0] odat;
   logic                   oval;
   logic                   osop;
   logic                   oeof;
   logic [StW-1:0]         ounder;
   logic                   ostat_val;

   int checks = 0;
   int passes = 0;
   int cyc = 0;

   // Reference model: frame position, frame length, underrun tally, pending stat report.
   bit         mRun;
   bit         mPend;
   int         mK;
   int         mLen;
   int         mUnder;
   int         mSnap;
   bit         eVal;
   bit         eSop;
   bit         eEof;
   bit         eStat;
   logic [7:0] eDat;
   int         eUnder;
   logic [7:0] seqByte = 8'hB4;

   sync_gen #(
      .pDAT_W   (DatW),
      .pTM_W    (TmW),
      .pSYNC_LEN(SyncLen),
      .pST_W    (StW)
   ) dut (
      .iclk      (iclk),
      .ireset    (ireset),
      .iena      (iena),
      .irun      (irun),
      .frame_time(frame_time),
      .idat      (idat),
      .ival      (ival),
      .ordy      (ordy),
      .odat      (odat),
      .oval      (oval),
      .osop      (osop),
      .oeof      (oeof),
      .ounder    (ounder),
      .ostat_val (ostat_val)
   );

   always #5 iclk = ~iclk;

   initial begin
      #5ms;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs === exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int clampLen(input int ft);
      return (ft < SyncLen + 1) ? SyncLen + 1 : ft;
   endfunction

   task automatic modelReset();
      mRun   = 1'b0;
      mPend  = 1'b0;
      mK     = 0;
      mLen   = 0;
      mUnder = 0;
      mSnap  = 0;
      eVal   = 1'b0;
      eSop   = 1'b0;
      eEof   = 1'b0;
      eStat  = 1'b0;
      eDat   = '0;
      eUnder = 0;
   endtask

   // One clock: drive, check the combinational ready, advance the model, then check registered outputs.
   task automatic applyStimulus(input bit ena, input bit val, input logic [7:0] dat);
      iena = ena;
      ival = val;
      idat = dat;
      #1;
      checkOutput("ordy", 32'(ordy), 32'(mRun && (mK >= SyncLen) && ena));

      eStat = mPend;
      if (mPend) eUnder = mSnap;
      mPend = 1'b0;
      eVal  = 1'b0;
      eSop  = 1'b0;
      eEof  = 1'b0;
      if (ena) begin
         if (!mRun && irun) begin
            mRun   = 1'b1;
            mK     = 0;
            mLen   = clampLen(int'(frame_time));
            mUnder = 0;
         end
         if (mRun) begin
            eVal = 1'b1;
            eSop = (mK == 0);
            if (mK < SyncLen) begin
               eDat = seqByte[7 - mK] ? 8'h7F : 8'h81;
            end else if (val) begin
               eDat = dat;
            end else begin
               eDat = 8'h00;
               if (mUnder < (1 << StW) - 1) mUnder++;
            end
            if (mK == mLen - 1) begin
               eEof   = 1'b1;
               mPend  = 1'b1;
               mSnap  = mUnder;
               mUnder = 0;
               if (irun) begin
                  mK   = 0;
                  mLen = clampLen(int'(frame_time));
               end else begin
                  mRun = 1'b0;
               end
            end else begin
               mK++;
            end
         end
      end

      @(posedge iclk);
      #1;
      cyc++;
      checkOutput("oval", 32'(oval), 32'(eVal));
      checkOutput("osop", 32'(osop), 32'(eSop));
      checkOutput("oeof", 32'(oeof), 32'(eEof));
      checkOutput("ostat_val", 32'(ostat_val), 32'(eStat));
      checkOutput("ounder", {28'd0, ounder}, 32'(eUnder));
      if (eVal) checkOutput("odat", {24'd0, odat}, {24'd0, eDat});
   endtask

   // mode 0: continuous strobe, 1: every 4th cycle, 2: random strobe.
   task automatic runCycles(input int n, input int mode, input int zeroPct);
      bit ena;
      bit val;
      for (int i = 0; i < n; i++) begin
         case (mode)
            0:       ena = 1'b1;
            1:       ena = ((cyc % 4) == 0);
            default: ena = 1'($urandom_range(0, 1));
         endcase
         val = (int'($urandom_range(0, 99)) >= zeroPct);
         applyStimulus(ena, val, 8'($urandom));
      end
   endtask

   initial begin
      modelReset();
      repeat (2) @(posedge iclk);
      #1;
      checkOutput("rst_oval", 32'(oval), 32'd0);
      checkOutput("rst_osop", 32'(osop), 32'd0);
      checkOutput("rst_oeof", 32'(oeof), 32'd0);
      checkOutput("rst_stat", 32'(ostat_val), 32'd0);
      checkOutput("rst_ounder", {28'd0, ounder}, 32'd0);
      checkOutput("rst_odat", {24'd0, odat}, 32'd0);
      checkOutput("rst_ordy", 32'(ordy), 32'd0);
      ireset = 1'b1;

      $display("[TB] basic frame");
      frame_time = 24'd20;
      irun = 1'b1;
      runCycles(20, 0, 0);
      irun = 1'b0;
      runCycles(10, 0, 0);

      $display("[TB] underruns");
      irun = 1'b1;
      runCycles(40, 0, 15);
      irun = 1'b0;
      runCycles(25, 0, 0);

      $display("[TB] frame length clamp");
      frame_time = 24'd4;
      irun = 1'b1;
      runCycles(27, 0, 0);
      irun = 1'b0;
      runCycles(15, 0, 0);

      $display("[TB] mid-frame frame_time change");
      frame_time = 24'd20;
      irun = 1'b1;
      runCycles(10, 0, 0);
      frame_time = 24'd30;
      runCycles(40, 0, 0);
      irun = 1'b0;
      runCycles(35, 0, 0);

      $display("[TB] gated strobe");
      frame_time = 24'd20;
      irun = 1'b1;
      runCycles(80, 1, 0);
      irun = 1'b0;
      runCycles(90, 1, 0);

      $display("[TB] stop mid-frame");
      irun = 1'b1;
      runCycles(5, 0, 0);
      irun = 1'b0;
      runCycles(30, 0, 0);

      $display("[TB] reset mid-frame");
      irun = 1'b1;
      runCycles(10, 0, 0);
      ireset = 1'b0;
      #1;
      checkOutput("arst_oval", 32'(oval), 32'd0);
      checkOutput("arst_osop", 32'(osop), 32'd0);
      checkOutput("arst_odat", {24'd0, odat}, 32'd0);
      @(posedge iclk);
      #1;
      checkOutput("arst_stat", 32'(ostat_val), 32'd0);
      checkOutput("arst_oeof", 32'(oeof), 32'd0);
      checkOutput("arst_ounder", {28'd0, ounder}, 32'd0);
      modelReset();
      ireset = 1'b1;
      runCycles(25, 0, 0);
      irun = 1'b0;
      runCycles(25, 0, 0);

      $display("[TB] underrun saturation");
      frame_time = 24'd40;
      irun = 1'b1;
      runCycles(39, 0, 100);
      irun = 1'b0;
      runCycles(50, 0, 100);

      $display("[TB] random soak");
      for (int b = 0; b < 60; b++) begin
         irun = ($urandom_range(0, 3) != 0);
         frame_time = 24'($urandom_range(4, 40));
         runCycles(50, 2, 20);
      end
      irun = 1'b0;
      runCycles(200, 0, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
